// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared geometry, state encoding and address-field helpers for the byte cache
package cache_pkg;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 8;
    localparam int INDEX_W  = 5;
    localparam int OFFSET_W = 2;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES    = 32;
    localparam int BEATS    = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        REFILL,
        RESPOND
    } state_t;

    typedef logic [BEATS-1:0][DATA_W-1:0] line_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/cache_array.sv
// rtl/cache_array.sv - 32-line tag/valid/data storage with combinational read
module cache_array
    import cache_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [INDEX_W-1:0]  rd_index_i,
    output logic                rd_valid_o,
    output logic [TAG_W-1:0]    rd_tag_o,
    output line_t               rd_line_o,
    input  logic                line_we_i,
    input  logic [INDEX_W-1:0]  line_index_i,
    input  logic                line_valid_i,
    input  logic [TAG_W-1:0]    line_tag_i,
    input  logic                byte_we_i,
    input  logic [INDEX_W-1:0]  byte_index_i,
    input  logic [OFFSET_W-1:0] byte_offset_i,
    input  logic [DATA_W-1:0]   byte_data_i
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    line_t            data_q [LINES];

    // Only the valid bits need clearing; stale tags and data are masked by them.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
        end else if (line_we_i) begin
            valid_q[line_index_i] <= line_valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_q[line_index_i] <= line_tag_i;
        end
        if (byte_we_i) begin
            data_q[byte_index_i][byte_offset_i] <= byte_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_line_o  = data_q[rd_index_i];

endmodule

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped read-only byte cache with 4-beat line refill
module cache_ctrl
    import cache_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ReqValid,
    input  logic [ADDR_W-1:0] ReqAddr,
    output logic              ReqReady,
    output logic              RespValid,
    output logic              Hit,
    output logic [DATA_W-1:0] MemSysOut,
    output logic              MemRdEn,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic              MemValid,
    input  logic [DATA_W-1:0] MemData
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [OFFSET_W-1:0] cnt_q, cnt_d;
    logic                resp_valid_q, resp_valid_d;
    logic                hit_q, hit_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    line_t               rd_line;
    logic                line_we;
    logic                line_valid;
    logic                byte_we;
    logic                lookup_hit;
    logic                last_beat;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [OFFSET_W-1:0] req_offset;

    assign req_tag    = addr_tag(addr_q);
    assign req_index  = addr_index(addr_q);
    assign req_offset = addr_offset(addr_q);

    cache_array u_array (
        .clk_i         (Clk),
        .reset_i       (Reset),
        .rd_index_i    (req_index),
        .rd_valid_o    (rd_valid),
        .rd_tag_o      (rd_tag),
        .rd_line_o     (rd_line),
        .line_we_i     (line_we),
        .line_index_i  (req_index),
        .line_valid_i  (line_valid),
        .line_tag_i    (req_tag),
        .byte_we_i     (byte_we),
        .byte_index_i  (req_index),
        .byte_offset_i (cnt_q),
        .byte_data_i   (MemData)
    );

    assign lookup_hit = rd_valid && (rd_tag == req_tag);
    assign last_beat  = (cnt_q == OFFSET_W'(BEATS - 1));

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        hit_d        = hit_q;
        data_d       = data_q;
        mem_rd_en_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        line_we      = 1'b0;
        line_valid   = 1'b0;
        byte_we      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    addr_d  = ReqAddr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lookup_hit) begin
                    resp_valid_d = 1'b1;
                    hit_d        = 1'b1;
                    data_d       = rd_line[req_offset];
                    state_d      = RESPOND;
                end else begin
                    // Invalidate up front so an aborted refill never leaves a half-filled valid line.
                    line_we     = 1'b1;
                    line_valid  = 1'b0;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = {req_tag, req_index, {OFFSET_W{1'b0}}};
                    cnt_d       = '0;
                    state_d     = REFILL;
                end
            end
            REFILL: begin
                if (MemValid) begin
                    byte_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (last_beat) begin
                        line_we      = 1'b1;
                        line_valid   = 1'b1;
                        resp_valid_d = 1'b1;
                        hit_d        = 1'b0;
                        // The final beat is still in flight to the array this cycle.
                        data_d       = (req_offset == cnt_q) ? MemData : rd_line[req_offset];
                        state_d      = RESPOND;
                    end
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            hit_q        <= 1'b0;
            data_q       <= '0;
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            hit_q        <= hit_d;
            data_q       <= data_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    assign ReqReady  = (state_q == IDLE);
    assign RespValid = resp_valid_q;
    assign Hit       = hit_q;
    assign MemSysOut = data_q;
    assign MemRdEn   = mem_rd_en_q;
    assign MemAddr   = mem_addr_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - directed self-checking bench for cache_ctrl
module tb_cache_ctrl;
    import cache_pkg::*;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              ReqValid;
    logic [ADDR_W-1:0] ReqAddr;
    logic              ReqReady;
    logic              RespValid;
    logic              Hit;
    logic [DATA_W-1:0] MemSysOut;
    logic              MemRdEn;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemValid;
    logic [DATA_W-1:0] MemData;

    int checks   = 0;
    int failures = 0;
    logic [DATA_W-1:0] mem [1024];

    cache_ctrl dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ReqValid  (ReqValid),
        .ReqAddr   (ReqAddr),
        .ReqReady  (ReqReady),
        .RespValid (RespValid),
        .Hit       (Hit),
        .MemSysOut (MemSysOut),
        .MemRdEn   (MemRdEn),
        .MemAddr   (MemAddr),
        .MemValid  (MemValid),
        .MemData   (MemData)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    // Issues one request, plays main memory with `gap` idle cycles between beats,
    // and checks response, latency, burst request and ReqReady while busy.
    task automatic do_req(input logic [ADDR_W-1:0] a, input int gap,
                          input logic exp_hit, input int exp_lat, output logic obs_hit);
        int   n;
        int   beat;
        int   wait_c;
        int   rd_cnt;
        logic got;
        logic burst;
        logic rdy_bad;
        logic [ADDR_W-1:0] seen_addr;
        logic [DATA_W-1:0] seen_data;
        logic [ADDR_W-1:0] beat_addr;
        ReqAddr  = a;
        ReqValid = 1'b1;
        chk("req_ready_idle", 32'(ReqReady), 32'd1);
        tick();
        ReqValid  = 1'b0;
        n = 1; beat = 0; wait_c = 0; rd_cnt = 0;
        got = 1'b0; burst = 1'b0; rdy_bad = 1'b0; obs_hit = 1'b0;
        seen_addr = '0; seen_data = '0;
        while (!got && n < 200) begin
            MemValid = 1'b0;
            if (burst && beat < BEATS) begin
                if (wait_c == 0) begin
                    beat_addr = {a[ADDR_W-1:OFFSET_W], 2'(beat)};
                    MemValid  = 1'b1;
                    MemData   = mem[beat_addr];
                    beat++;
                    wait_c = gap;
                end else begin
                    wait_c--;
                end
            end
            if (MemRdEn) begin
                rd_cnt++;
                seen_addr = MemAddr;
                burst = 1'b1;
            end
            if (RespValid) begin
                got       = 1'b1;
                obs_hit   = Hit;
                seen_data = MemSysOut;
            end else begin
                if (ReqReady) rdy_bad = 1'b1;
                tick();
                n++;
            end
        end
        MemValid = 1'b0;
        chk("resp_seen", 32'(got), 32'd1);
        chk("latency", 32'(n), 32'(exp_lat));
        chk("hit", 32'(obs_hit), 32'(exp_hit));
        chk("data", 32'(seen_data), 32'(mem[a]));
        chk("mem_rd_count", 32'(rd_cnt), exp_hit ? 32'd0 : 32'd1);
        if (!exp_hit) chk("mem_addr", 32'(seen_addr), 32'({a[ADDR_W-1:OFFSET_W], 2'b00}));
        chk("ready_low_busy", 32'(rdy_bad), 32'd0);
        tick();
    endtask

    initial begin
        logic h;
        int   hits;
        int   misses;
        for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 7) + 3);
        mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC; mem[3] = 8'hDD;
        ReqValid = 1'b0; ReqAddr = '0; MemValid = 1'b0; MemData = '0;

        do_reset();
        chk("rst_ready", 32'(ReqReady), 32'd1);
        chk("rst_resp_valid", 32'(RespValid), 32'd0);
        chk("rst_hit", 32'(Hit), 32'd0);
        chk("rst_memsysout", 32'(MemSysOut), 32'd0);
        chk("rst_mem_rd_en", 32'(MemRdEn), 32'd0);
        chk("rst_mem_addr", 32'(MemAddr), 32'd0);

        do_req(10'h000, 0, 1'b0, 7, h);
        chk("cold_data_aa", 32'(MemSysOut), 32'hAA);
        do_req(10'h003, 0, 1'b1, 2, h);
        chk("hit_data_dd", 32'(MemSysOut), 32'hDD);
        do_req(10'h080, 0, 1'b0, 7, h);
        do_req(10'h000, 0, 1'b0, 7, h);
        do_req(10'h105, 2, 1'b0, 13, h);
        do_req(10'h107, 0, 1'b1, 2, h);

        // Abort a refill after two beats, then feed stray beats that must be ignored.
        ReqAddr = 10'h20A; ReqValid = 1'b1;
        tick();
        ReqValid = 1'b0;
        tick();
        chk("abort_mem_rd_en", 32'(MemRdEn), 32'd1);
        chk("abort_mem_addr", 32'(MemAddr), 32'h208);
        tick();
        MemValid = 1'b1; MemData = mem[10'h208];
        tick();
        MemData = mem[10'h209];
        tick();
        MemValid = 1'b0; Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("abort_ready", 32'(ReqReady), 32'd1);
        MemValid = 1'b1; MemData = 8'hEE;
        tick();
        tick();
        MemValid = 1'b0;
        chk("abort_no_resp", 32'(RespValid), 32'd0);
        chk("abort_idle", 32'(ReqReady), 32'd1);
        do_req(10'h20A, 0, 1'b0, 7, h);
        do_req(10'h20B, 0, 1'b1, 2, h);

        do_reset();
        hits = 0; misses = 0;
        for (int i = 0; i < 100; i++) begin
            do_req(10'(i), 0, (i % 4) != 0, ((i % 4) != 0) ? 2 : 7, h);
            if (h) hits++; else misses++;
        end
        chk("sweep_hits", 32'(hits), 32'd75);
        chk("sweep_misses", 32'(misses), 32'd25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
